// File: rtl/dyna_link_scheduler.sv
// Shares one half-duplex Dynamixel link between toggle-triggered host commands and a periodic
// status poll. Round-robin grant, bus turnaround gap, ISSUE timeout, results back via dyna_read.
module dyna_link_scheduler #(
    parameter int POLL_PERIOD = 50000,
    parameter int TIMEOUT     = 20000,
    parameter int GAP         = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dyna_write,
    input  logic        poll_en,
    input  logic [7:0]  poll_id,
    input  logic [7:0]  poll_addr,
    output logic        link_req,
    output logic        link_rw,
    output logic [7:0]  link_id,
    output logic [7:0]  link_addr,
    output logic [7:0]  link_wdata,
    input  logic        link_ack,
    input  logic [7:0]  link_rdata,
    input  logic        link_err,
    output logic [31:0] dyna_read,
    output logic        busy
);

    localparam int PW = $clog2(POLL_PERIOD);
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [25:0]   cmd_q, cmd_d;
    logic          seq_seen_q, seq_seen_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          poll_pend_q, poll_pend_d;
    logic          last_poll_q, last_poll_d;
    logic          cur_poll_q, cur_poll_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          link_req_q, link_req_d;
    logic          link_rw_q, link_rw_d;
    logic [7:0]    link_id_q, link_id_d;
    logic [7:0]    link_addr_q, link_addr_d;
    logic [7:0]    link_wdata_q, link_wdata_d;
    logic          seq_done_q, seq_done_d;
    logic          timeout_q, timeout_d;
    logic          err_q, err_d;
    logic [7:0]    poll_rdata_q, poll_rdata_d;
    logic [7:0]    host_rdata_q, host_rdata_d;
    logic [7:0]    host_id_q, host_id_d;

    logic host_pend, gap_done, grant, pick_poll;
    logic unused_dw;

    assign unused_dw = ^dyna_write[29:24];

    // cmd_q keeps {toggle, rw, id, addr, wdata}; registering it aligns the toggle with its payload.
    assign host_pend = cmd_q[25] != seq_seen_q;
    assign gap_done  = (state_q == S_GAP) && (gap_cnt_q == GAP_LAST);
    assign grant     = ((state_q == S_IDLE) || gap_done) && (host_pend || poll_pend_q);
    assign pick_poll = (host_pend && poll_pend_q) ? !last_poll_q : poll_pend_q;

    always_comb begin
        state_d      = state_q;
        cmd_d        = {dyna_write[31:30], dyna_write[23:0]};
        seq_seen_d   = seq_seen_q;
        poll_cnt_d   = poll_cnt_q;
        poll_pend_d  = poll_pend_q;
        last_poll_d  = last_poll_q;
        cur_poll_d   = cur_poll_q;
        to_cnt_d     = to_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        link_req_d   = link_req_q;
        link_rw_d    = link_rw_q;
        link_id_d    = link_id_q;
        link_addr_d  = link_addr_q;
        link_wdata_d = link_wdata_q;
        seq_done_d   = seq_done_q;
        timeout_d    = timeout_q;
        err_d        = err_q;
        poll_rdata_d = poll_rdata_q;
        host_rdata_d = host_rdata_q;
        host_id_d    = host_id_q;

        // An expiry while a poll is already pending is simply absorbed.
        if (!poll_en) begin
            poll_cnt_d  = '0;
            poll_pend_d = 1'b0;
        end else if (poll_cnt_q == POLL_LAST) begin
            poll_cnt_d  = '0;
            poll_pend_d = 1'b1;
        end else begin
            poll_cnt_d  = poll_cnt_q + 1'b1;
        end

        case (state_q)
            S_ISSUE: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (link_ack) begin
                    state_d    = S_GAP;
                    gap_cnt_d  = '0;
                    link_req_d = 1'b0;
                    timeout_d  = 1'b0;
                    err_d      = link_err;
                    if (cur_poll_q) begin
                        poll_rdata_d = link_rdata;
                    end else begin
                        host_rdata_d = link_rw_q ? 8'h00 : link_rdata;
                        host_id_d    = link_id_q;
                        seq_done_d   = seq_seen_q;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d    = S_GAP;
                    gap_cnt_d  = '0;
                    link_req_d = 1'b0;
                    timeout_d  = 1'b1;
                    err_d      = 1'b0;
                    if (!cur_poll_q) begin
                        seq_done_d = seq_seen_q;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_done) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // The last turnaround cycle may grant directly so back-to-back work sees exactly GAP idle cycles.
        if (grant) begin
            state_d    = S_ISSUE;
            to_cnt_d   = '0;
            link_req_d = 1'b1;
            if (pick_poll) begin
                link_rw_d    = 1'b0;
                link_id_d    = poll_id;
                link_addr_d  = poll_addr;
                link_wdata_d = 8'h00;
                poll_pend_d  = 1'b0;
                cur_poll_d   = 1'b1;
                last_poll_d  = 1'b1;
            end else begin
                link_rw_d    = cmd_q[24];
                link_id_d    = cmd_q[23:16];
                link_addr_d  = cmd_q[15:8];
                link_wdata_d = cmd_q[7:0];
                seq_seen_d   = cmd_q[25];
                cur_poll_d   = 1'b0;
                last_poll_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            seq_seen_q   <= 1'b0;
            poll_cnt_q   <= '0;
            poll_pend_q  <= 1'b0;
            last_poll_q  <= 1'b1;
            cur_poll_q   <= 1'b0;
            to_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            link_req_q   <= 1'b0;
            link_rw_q    <= 1'b0;
            link_id_q    <= '0;
            link_addr_q  <= '0;
            link_wdata_q <= '0;
            seq_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
            err_q        <= 1'b0;
            poll_rdata_q <= '0;
            host_rdata_q <= '0;
            host_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            seq_seen_q   <= seq_seen_d;
            poll_cnt_q   <= poll_cnt_d;
            poll_pend_q  <= poll_pend_d;
            last_poll_q  <= last_poll_d;
            cur_poll_q   <= cur_poll_d;
            to_cnt_q     <= to_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            link_req_q   <= link_req_d;
            link_rw_q    <= link_rw_d;
            link_id_q    <= link_id_d;
            link_addr_q  <= link_addr_d;
            link_wdata_q <= link_wdata_d;
            seq_done_q   <= seq_done_d;
            timeout_q    <= timeout_d;
            err_q        <= err_d;
            poll_rdata_q <= poll_rdata_d;
            host_rdata_q <= host_rdata_d;
            host_id_q    <= host_id_d;
        end
    end

    assign link_req   = link_req_q;
    assign link_rw    = link_rw_q;
    assign link_id    = link_id_q;
    assign link_addr  = link_addr_q;
    assign link_wdata = link_wdata_q;
    assign busy       = state_q != S_IDLE;
    assign dyna_read  = {seq_done_q, busy, timeout_q, err_q, 4'b0000,
                         poll_rdata_q, host_rdata_q, host_id_q};

endmodule

// File: tb/tb_dyna_link_scheduler.sv
// Scenario bench for dyna_link_scheduler: random host/poll traffic against a transaction-level
// model of the dyna_read register and the grant/turnaround timing rules.
module tb_dyna_link_scheduler;

    localparam int PP = 100;
    localparam int TO = 30;
    localparam int GP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dyna_write;
    logic        poll_en;
    logic [7:0]  poll_id, poll_addr;
    logic        link_req, link_rw;
    logic [7:0]  link_id, link_addr, link_wdata;
    logic        link_ack;
    logic [7:0]  link_rdata;
    logic        link_err;
    logic [31:0] dyna_read;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic       m_tog, m_seq, m_to, m_err;
    logic [7:0] m_prd, m_hrd, m_hid;

    dyna_link_scheduler #(.POLL_PERIOD(PP), .TIMEOUT(TO), .GAP(GP)) dut (
        .clk(clk), .rst_n(rst_n), .dyna_write(dyna_write), .poll_en(poll_en),
        .poll_id(poll_id), .poll_addr(poll_addr), .link_req(link_req), .link_rw(link_rw),
        .link_id(link_id), .link_addr(link_addr), .link_wdata(link_wdata),
        .link_ack(link_ack), .link_rdata(link_rdata), .link_err(link_err),
        .dyna_read(dyna_read), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_read(input logic b);
        return {m_seq, b, m_to, m_err, 4'b0000, m_prd, m_hrd, m_hid};
    endfunction

    task automatic model_clear();
        m_tog = 0; m_seq = 0; m_to = 0; m_err = 0;
        m_prd = 0; m_hrd = 0; m_hid = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0; dyna_write = 0; poll_en = 0; link_ack = 0;
        link_rdata = 0; link_err = 0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (link_req !== 1'b1 && n < 300);
    endtask

    task automatic test_reset();
        rst_n = 0; dyna_write = 0; poll_en = 0; link_ack = 0;
        link_rdata = 0; link_err = 0; poll_id = 0; poll_addr = 0;
        model_clear();
        repeat (3) @(negedge clk);
        total++;
        if ({link_req, busy, dyna_read} !== 34'h0)
            begin bad++; $display("FAIL reset_outputs: got req=%b busy=%b rd=%h want all 0", link_req, busy, dyna_read); end
        total++;
        if ({link_rw, link_id, link_addr, link_wdata} !== 25'h0)
            begin bad++; $display("FAIL reset_link_fields: got %h want 0", {link_rw, link_id, link_addr, link_wdata}); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic host_cmd(input logic rw, input logic [7:0] id, input logic [7:0] addr,
                            input logic [7:0] wd, input int dly, input logic [7:0] rd,
                            input logic er, input logic spur, input logic dbl);
        int n;
        m_tog = ~m_tog;
        dyna_write = {m_tog, rw, 6'b0, id, addr, wd};
        @(negedge clk);
        total++;
        if (link_req !== 1'b0)
            begin bad++; $display("FAIL host_latency_early: got req=%b want 0", link_req); end
        @(negedge clk);
        total++;
        if (link_req !== 1'b1)
            begin bad++; $display("FAIL host_latency: got req=%b want 1", link_req); end
        n = 0;
        while (link_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        total++;
        if ({link_rw, link_id, link_addr, link_wdata} !== {rw, id, addr, wd})
            begin bad++; $display("FAIL host_fields: got %h want %h", {link_rw, link_id, link_addr, link_wdata}, {rw, id, addr, wd}); end
        total++;
        if (busy !== 1'b1 || dyna_read[30] !== 1'b1)
            begin bad++; $display("FAIL host_busy: got busy=%b rd30=%b want 1", busy, dyna_read[30]); end
        if (dly > 0) begin
            if (dbl) begin
                dyna_write[31] = ~m_tog; dyna_write[7:0] = ~wd;
                @(negedge clk);
                dyna_write[31] = m_tog;
                @(negedge clk);
                repeat (dly - 3) @(negedge clk);
            end else begin
                repeat (dly - 1) @(negedge clk);
            end
            total++;
            if ({link_req, link_rw, link_id, link_addr, link_wdata} !== {1'b1, rw, id, addr, wd})
                begin bad++; $display("FAIL host_stable: got %h want %h", {link_req, link_rw, link_id, link_addr, link_wdata}, {1'b1, rw, id, addr, wd}); end
            link_ack = 1; link_rdata = rd; link_err = er;
            @(negedge clk);
            link_ack = 0; link_rdata = 8'($urandom); link_err = 0;
            m_seq = m_tog; m_to = 0; m_err = er; m_hrd = rw ? 8'h00 : rd; m_hid = id;
        end else begin
            n = 1;
            while (link_req === 1'b1 && n < TO + 5) begin
                @(negedge clk);
                if (link_req === 1'b1) n++;
            end
            total++;
            if (n != TO)
                begin bad++; $display("FAIL timeout_len: got %0d req cycles want %0d", n, TO); end
            m_seq = m_tog; m_to = 1; m_err = 0;
        end
        total++;
        if (link_req !== 1'b0 || dyna_read !== exp_read(1'b1))
            begin bad++; $display("FAIL host_done: got req=%b rd=%h want req=0 rd=%h", link_req, dyna_read, exp_read(1'b1)); end
        n = 0;
        if (spur) begin link_ack = 1; link_rdata = 8'hEE; link_err = 1; end
        while (busy === 1'b1 && n < GP + 10) begin
            n++;
            @(negedge clk);
            link_ack = 0; link_err = 0;
        end
        total++;
        if (n != GP)
            begin bad++; $display("FAIL gap_len: got %0d busy cycles want %0d", n, GP); end
        total++;
        if (link_req !== 1'b0 || dyna_read !== exp_read(1'b0))
            begin bad++; $display("FAIL after_gap: got req=%b rd=%h want req=0 rd=%h", link_req, dyna_read, exp_read(1'b0)); end
    endtask

    task automatic test_host_write();
        host_cmd(1'b1, 8'h01, 8'h1E, 8'h55, 5, 8'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_host_read_err();
        host_cmd(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 3, 8'hA7, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        host_cmd(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random_host();
        int d;
        for (int i = 0; i < 6; i++) begin
            d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TO));
            host_cmd(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), d,
                     8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_collapse();
        int n;
        host_cmd(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 4, 8'($urandom), 1'b0, 1'b0, 1'b1);
        n = 0;
        repeat (20) begin @(negedge clk); if (link_req !== 1'b0) n++; end
        total++;
        if (n != 0)
            begin bad++; $display("FAIL collapse_no_grant: got %0d req cycles want 0", n); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ida, idb, adb, wdb;
        int n;
        ida = 8'($urandom); idb = 8'($urandom); adb = 8'($urandom); wdb = 8'($urandom);
        m_tog = ~m_tog;
        dyna_write = {m_tog, 1'b1, 6'b0, ida, 8'h10, 8'h20};
        repeat (2) @(negedge clk);
        link_ack = 1; link_rdata = 8'h33; link_err = 0;
        @(negedge clk);
        link_ack = 0;
        m_seq = m_tog; m_to = 0; m_err = 0; m_hrd = 8'h00; m_hid = ida;
        m_tog = ~m_tog;
        dyna_write = {m_tog, 1'b1, 6'b0, idb, adb, wdb};
        n = 1;
        while (link_req !== 1'b1 && n < GP + 10) begin
            @(negedge clk);
            if (link_req !== 1'b1) n++;
        end
        total++;
        if (n != GP)
            begin bad++; $display("FAIL b2b_gap: got %0d idle cycles want %0d", n, GP); end
        total++;
        if ({link_rw, link_id, link_addr, link_wdata, busy} !== {1'b1, idb, adb, wdb, 1'b1})
            begin bad++; $display("FAIL b2b_fields: got %h want %h", {link_rw, link_id, link_addr, link_wdata, busy}, {1'b1, idb, adb, wdb, 1'b1}); end
        total++;
        if (dyna_read !== exp_read(1'b1))
            begin bad++; $display("FAIL b2b_first_result: got %h want %h", dyna_read, exp_read(1'b1)); end
        link_ack = 1; link_rdata = 8'h44; link_err = 0;
        @(negedge clk);
        link_ack = 0;
        m_seq = m_tog; m_hid = idb;
        n = 0;
        while (busy === 1'b1 && n < GP + 10) begin n++; @(negedge clk); end
        total++;
        if (dyna_read !== exp_read(1'b0))
            begin bad++; $display("FAIL b2b_second_result: got %h want %h", dyna_read, exp_read(1'b0)); end
    endtask

    task automatic test_reset_mid_issue();
        int n;
        m_tog = ~m_tog;
        dyna_write = {m_tog, 1'b0, 6'b0, 8'h07, 8'h24, 8'h00};
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        dyna_write = 0;
        #1;
        total++;
        if ({link_req, busy, dyna_read} !== 34'h0)
            begin bad++; $display("FAIL reset_mid_issue: got req=%b busy=%b rd=%h want all 0", link_req, busy, dyna_read); end
        model_clear();
        @(negedge clk);
        rst_n = 1;
        n = 0;
        repeat (20) begin @(negedge clk); if (link_req !== 1'b0) n++; end
        total++;
        if (n != 0)
            begin bad++; $display("FAIL reset_no_grant: got %0d req cycles want 0", n); end
    endtask

    task automatic test_contention();
        logic [7:0] pid, pad, hid, prd;
        logic er;
        int n;
        apply_reset();
        pid = 8'($urandom); pad = 8'($urandom); hid = 8'($urandom);
        prd = 8'($urandom); er = 1'($urandom);
        poll_id = pid; poll_addr = pad; poll_en = 1;
        repeat (PP - 1) @(negedge clk);
        m_tog = 1;
        dyna_write = {1'b1, 1'b1, 6'b0, hid, 8'h2A, 8'h5A};
        repeat (2) @(negedge clk);
        total++;
        if ({link_req, link_rw, link_id} !== {1'b1, 1'b1, hid})
            begin bad++; $display("FAIL contend_host_first: got %h want %h", {link_req, link_rw, link_id}, {1'b1, 1'b1, hid}); end
        @(negedge clk);
        link_ack = 1; link_rdata = 8'h99; link_err = 0;
        @(negedge clk);
        link_ack = 0;
        m_seq = 1; m_to = 0; m_err = 0; m_hrd = 8'h00; m_hid = hid;
        n = 1;
        while (link_req !== 1'b1 && n < GP + 10) begin
            @(negedge clk);
            if (link_req !== 1'b1) n++;
        end
        total++;
        if (n != GP)
            begin bad++; $display("FAIL contend_gap: got %0d idle cycles want %0d", n, GP); end
        total++;
        if ({link_rw, link_id, link_addr, link_wdata, busy} !== {1'b0, pid, pad, 8'h00, 1'b1})
            begin bad++; $display("FAIL contend_poll_next: got %h want %h", {link_rw, link_id, link_addr, link_wdata, busy}, {1'b0, pid, pad, 8'h00, 1'b1}); end
        link_ack = 1; link_rdata = prd; link_err = er;
        @(negedge clk);
        link_ack = 0; link_err = 0;
        m_prd = prd; m_err = er;
        total++;
        if (dyna_read !== exp_read(1'b1))
            begin bad++; $display("FAIL contend_poll_result: got %h want %h", dyna_read, exp_read(1'b1)); end
        poll_en = 0;
        n = 0;
        while (busy === 1'b1 && n < GP + 10) begin n++; @(negedge clk); end
    endtask

    task automatic test_poll_period();
        logic [7:0] pid, pad, prd;
        logic er;
        int n, prev;
        pid = 8'($urandom); pad = 8'($urandom);
        poll_id = pid; poll_addr = pad;
        @(negedge clk);
        poll_en = 1;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_rise(n);
            total++;
            if (i == 0 && n != PP + 1)
                begin bad++; $display("FAIL poll_first_latency: got %0d cycles want %0d", n, PP + 1); end
            else if (i > 0 && cyc - prev != PP)
                begin bad++; $display("FAIL poll_period: got %0d cycles want %0d", cyc - prev, PP); end
            prev = cyc;
            total++;
            if ({link_req, link_rw, link_id, link_addr, link_wdata} !== {1'b1, 1'b0, pid, pad, 8'h00})
                begin bad++; $display("FAIL poll_fields: got %h want %h", {link_req, link_rw, link_id, link_addr, link_wdata}, {1'b1, 1'b0, pid, pad, 8'h00}); end
            if (i == 2) poll_en = 0;
            prd = 8'($urandom); er = 1'($urandom);
            repeat (2) @(negedge clk);
            link_ack = 1; link_rdata = prd; link_err = er;
            @(negedge clk);
            link_ack = 0; link_err = 0;
            m_prd = prd; m_err = er; m_to = 0;
            total++;
            if (link_req !== 1'b0 || dyna_read !== exp_read(1'b1))
                begin bad++; $display("FAIL poll_result: got req=%b rd=%h want req=0 rd=%h", link_req, dyna_read, exp_read(1'b1)); end
        end
        n = 0;
        repeat (2 * PP + 50) begin @(negedge clk); if (link_req !== 1'b0) n++; end
        total++;
        if (n != 0)
            begin bad++; $display("FAIL poll_disabled: got %0d req cycles want 0", n); end
    endtask

    initial begin
        test_reset();
        test_host_write();
        test_host_read_err();
        test_timeout();
        test_random_host();
        test_collapse();
        test_back_to_back();
        test_reset_mid_issue();
        test_contention();
        test_poll_period();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
